// File: rtl/ram_sp_param_if.sv
// Bus-side interface for ram_sp_param: request controls, write data and read results.
// The par_inj/rd_perr pair exists only when RAM_PARITY_EN is defined.
interface ram_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              cs;
    logic              wa;
    logic              oa;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
`ifdef RAM_PARITY_EN
    logic              par_inj;
    logic              rd_perr;
`endif

    modport master (
        output cs, wa, oa, addr, data_in,
`ifdef RAM_PARITY_EN
        output par_inj,
        input  rd_perr,
`endif
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  cs, wa, oa, addr, data_in,
`ifdef RAM_PARITY_EN
        input  par_inj,
        output rd_perr,
`endif
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with registered reads and a zero-fill sweep after reset.
// Optional per-word even parity is enabled with RAM_PARITY_EN.
module ram_sp_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic          clk,
    input logic          rst_n,
    ram_sp_param_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic              we;
    logic              rd_en;
    logic [ADDR_W-1:0] waddr;
    logic [MEM_W-1:0]  wdata;
    logic [MEM_W-1:0]  rword;

    assign rword = mem[bus.addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= clr_ptr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_ptr_nx = clr_ptr;
        we         = 1'b0;
        rd_en      = 1'b0;
        waddr      = bus.addr;
`ifdef RAM_PARITY_EN
        wdata      = {^bus.data_in ^ bus.par_inj, bus.data_in};
`else
        wdata      = bus.data_in;
`endif
        unique case (state)
            CLEAR: begin
                // All-zero word carries even parity 0, so the sweep stores valid parity too
                we         = 1'b1;
                waddr      = clr_ptr;
                wdata      = '0;
                clr_ptr_nx = clr_ptr + 1'b1;
                if (clr_ptr == '1) state_nx = IDLE;
            end
            IDLE: begin
                we    = bus.cs & bus.wa & ~bus.oa;
                rd_en = bus.cs & bus.oa & ~bus.wa;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
            bus.rd_valid <= 1'b0;
            bus.busy     <= 1'b1;
`ifdef RAM_PARITY_EN
            bus.rd_perr  <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= rd_en;
            bus.busy     <= (state_nx == CLEAR);
            if (rd_en) bus.data_out <= rword[DATA_W-1:0];
`ifdef RAM_PARITY_EN
            bus.rd_perr  <= rd_en & (^rword);
`endif
        end
    end
endmodule
